sync_fifo_flags: RTL and testbench
==================================

# sync_fifo_flags

Parametrised synchronous FIFO that succeeds the fixed 8-bit/16-deep FIFO. It adds an occupancy count output, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags with clear, and a selectable first-word-fall-through (FWFT) read mode. It sits between a producer and a consumer in the same clock domain and is the DUT for the next-generation FIFO assertion bench.

## Interface

- DATA_WIDTH, 8, data bits per entry (≥1)
- DEPTH, 16, number of entries; power of two, ≥2
- AF_THRESH, DEPTH-2, almost_full asserts when cnt ≥ AF_THRESH (1..DEPTH)
- AE_THRESH, 2, almost_empty asserts when cnt ≤ AE_THRESH (0..DEPTH-1)
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  one clock; reset is asynchronous and active-high
- wr_en  input  1  write request
- din  input  DATA_WIDTH  write data
- rd_en  input  1  read request (pop in FWFT mode)
- dout  output  DATA_WIDTH  read data
- full  output  1  cnt == DEPTH
- empty  output  1  cnt == 0
- almost_full  output  1  cnt ≥ AF_THRESH
- almost_empty  output  1  cnt ≤ AE_THRESH
- cnt  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: write attempted while full
- underflow  output  1  sticky: read attempted while empty
- clr_err  input  1  synchronous clear of overflow/underflow

## Operation

- Storage: DEPTH × DATA_WIDTH array, not reset. rd_ptr, wrt_ptr each $clog2(DEPTH) bits, wrap DEPTH-1 → 0 naturally.
- Write accepted iff wr_en && !full: mem[wrt_ptr] ← din, wrt_ptr+1.
- Read accepted iff rd_en && !empty: rd_ptr+1.
- Acceptance uses pre-edge flags; a read in the same cycle never frees room for a write while full, and a write never makes a read legal while empty.
- cnt: +1 on write only, −1 on read only, unchanged on both or neither. Never exceeds DEPTH or drops below 0.
- full, empty, almost_full, almost_empty: combinational decodes of registered cnt.
- Standard mode (FWFT=0): on accepted read, dout ← mem[rd_ptr] at that edge. dout holds otherwise, including on rejected reads.
- FWFT mode (FWFT=1): dout = mem[rd_ptr] combinationally, so the head word is valid whenever !empty. rd_en pops it. dout is don't-care while empty.
- Errors: wr_en && full sets overflow; the write is dropped and no state changes. rd_en && empty sets underflow; dout and pointers are unchanged. Both flags stay set until clr_err. If clr_err and a new error occur in the same cycle, the set wins.
- Reset mid-operation discards all contents immediately, with no pending write or read completing.

## Timing

- Reset values: rd_ptr=0, wrt_ptr=0, cnt=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0. In standard mode dout=0.
- Write-to-flag latency: 1 cycle. After the edge accepting the first write, cnt=1 and empty=0.
- Write-to-read latency:
  - Standard mode: data is readable on the cycle after the write edge, and dout is valid 1 cycle after the accepted read edge.
  - FWFT mode: dout shows the word on the cycle after its write edge when the FIFO was empty.
- Throughput: one write and one read per cycle sustained when 0 < cnt < DEPTH.
- Error flags are visible the cycle after the offending edge. clr_err takes effect at the next edge.

## Test plan

- Reset/flags: assert rst asynchronously mid-cycle. Required: all outputs at their reset values immediately. After release: empty=1, almost_empty=1, cnt=0.
- Fill/drain with DEPTH=16, AF=14, AE=2, FWFT=0: write 0x00..0x0F.
  - cnt steps 1..16; almost_empty drops at cnt=3; almost_full rises at cnt=14; full at 16.
  - Read 16 words: dout = 0x00..0x0F in order, each one cycle after rd_en; empty returns at cnt=0.
- Wrap-around: repeat 3× (write 10, read 10). Required: data order preserved across pointer wrap and cnt=0 at the end.
- Simultaneous: at cnt=5, wr_en=rd_en=1 for 8 cycles. Required: cnt stays 5 and dout emits the oldest words in order. At full with both asserted: read accepted, write dropped, overflow=1, cnt=15.
- Errors: write while full sets overflow; read while empty sets underflow and dout is unchanged. Assert clr_err together with a new overflow: overflow stays 1. Assert clr_err alone: both flags clear next cycle.
- FWFT=1: write 0xA5 into the empty FIFO. Required: dout=0xA5 the next cycle without rd_en. Pulse rd_en: empty=1 and cnt=0.

Source files
------------

// File: rtl/sync_fifo_flags.sv
// Parametrised single-clock FIFO with occupancy count, almost flags, sticky errors and optional FWFT read.
// Flags follow a write or read by 1 cycle; full drops writes, empty ignores reads, and both set a sticky error.
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  parameter bit FWFT       = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [DATA_WIDTH-1:0]        din,
  input  logic                         rd_en,
  output logic [DATA_WIDTH-1:0]        dout,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH):0]       cnt,
  output logic                         overflow,
  output logic                         underflow,
  input  logic                         clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wrt_ptr;
  logic [CW-1:0]         cnt_q;
  logic                  wr_acc;
  logic                  rd_acc;

  // Flags decode only the registered count, so acceptance always sees pre-edge state.
  assign full         = (cnt_q == FULL_CNT);
  assign empty        = (cnt_q == '0);
  assign almost_full  = (cnt_q >= AF_CNT);
  assign almost_empty = (cnt_q <= AE_CNT);
  assign cnt          = cnt_q;

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wrt_ptr <= '0;
      cnt_q   <= '0;
    end else begin
      if (wr_acc) wrt_ptr <= wrt_ptr + AW'(1);
      if (rd_acc) rd_ptr  <= rd_ptr + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // A fresh error outranks a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (wr_en && full)  || (overflow  && !clr_err);
      underflow <= (rd_en && empty) || (underflow && !clr_err);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem[wrt_ptr] <= din;
  end

  generate
    if (FWFT) begin : g_fwft
      assign dout = mem[rd_ptr];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)         dout_q <= '0;
        else if (rd_acc) dout_q <= mem[rd_ptr];
      end
      assign dout = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Drives a standard-mode and an FWFT-mode FIFO with identical stimulus and checks both against a queue model.
module tb_sync_fifo_flags;
  localparam int DW = 8;
  localparam int D  = 16;
  localparam int AF = 14;
  localparam int AE = 2;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en, rd_en, clr_err;
  logic [DW-1:0] din;

  logic [DW-1:0] s_dout, f_dout;
  logic          s_full, s_empty, s_af, s_ae, s_ovf, s_ufl;
  logic          f_full, f_empty, f_af, f_ae, f_ovf, f_ufl;
  logic [CW-1:0] s_cnt, f_cnt;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] q[$];
  logic          m_ovf, m_ufl;
  logic [DW-1:0] m_dout;

  sync_fifo_flags #(.DATA_WIDTH(DW), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1'b0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(s_dout),
    .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae), .cnt(s_cnt),
    .overflow(s_ovf), .underflow(s_ufl), .clr_err(clr_err)
  );

  sync_fifo_flags #(.DATA_WIDTH(DW), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(f_dout),
    .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae), .cnt(f_cnt),
    .overflow(f_ovf), .underflow(f_ufl), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  // Advance one edge, update the model from the inputs seen at that edge, then settle.
  task automatic tick();
    bit was_full, was_empty;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_ovf  = 1'b0;
      m_ufl  = 1'b0;
      m_dout = '0;
    end else begin
      was_full  = (q.size() == D);
      was_empty = (q.size() == 0);
      if (wr_en && was_full) m_ovf = 1'b1; else if (clr_err) m_ovf = 1'b0;
      if (rd_en && was_empty) m_ufl = 1'b1; else if (clr_err) m_ufl = 1'b0;
      if (rd_en && !was_empty) m_dout = q.pop_front();
      if (wr_en && !was_full) q.push_back(din);
    end
    #1;
  endtask

  task automatic drive(input logic w, input logic r, input logic c, input logic [DW-1:0] d);
    wr_en   = w;
    rd_en   = r;
    clr_err = c;
    din     = d;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; din = '0;
    repeat (2) tick();
    rst = 1'b0;
    drive(0, 0, 0, 8'h00);
    total++;
    if (s_cnt !== 0 || s_empty !== 1'b1 || s_ae !== 1'b1 || s_full !== 1'b0 || s_af !== 1'b0 ||
        s_ovf !== 1'b0 || s_ufl !== 1'b0 || s_dout !== 8'h00) begin
      bad++;
      $display("FAIL reset_release: cnt=%0d empty=%b ae=%b full=%b af=%b ovf=%b ufl=%b dout=%h want 0 1 1 0 0 0 0 00",
               s_cnt, s_empty, s_ae, s_full, s_af, s_ovf, s_ufl, s_dout);
    end
    // Load some state, then hit reset mid-cycle with a write pending.
    drive(1, 0, 0, 8'h11);
    drive(1, 0, 0, 8'h22);
    drive(1, 1, 0, 8'h33);
    drive(0, 0, 0, 8'h00);
    drive(1, 1, 0, 8'h44);
    #3;
    rst = 1'b1;
    #1;
    total++;
    if (s_cnt !== 0 || s_empty !== 1'b1 || s_ae !== 1'b1 || s_full !== 1'b0 || s_af !== 1'b0 ||
        s_ovf !== 1'b0 || s_ufl !== 1'b0 || s_dout !== 8'h00 || f_cnt !== 0 || f_empty !== 1'b1) begin
      bad++;
      $display("FAIL reset_async: cnt=%0d empty=%b ae=%b full=%b af=%b ovf=%b ufl=%b dout=%h fcnt=%0d want 0 1 1 0 0 0 0 00 0",
               s_cnt, s_empty, s_ae, s_full, s_af, s_ovf, s_ufl, s_dout, f_cnt);
    end
    tick();
    #2;
    rst = 1'b0;
    drive(0, 0, 0, 8'h00);
    total++;
    if (s_cnt !== 0 || s_empty !== 1'b1 || s_ae !== 1'b1) begin
      bad++;
      $display("FAIL reset_after: cnt=%0d empty=%b ae=%b want 0 1 1", s_cnt, s_empty, s_ae);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < D; i++) begin
      drive(1, 0, 0, 8'(i));
      total++;
      if (s_cnt !== CW'(i + 1) || s_ae !== (i + 1 <= AE) || s_af !== (i + 1 >= AF) ||
          s_full !== (i + 1 == D) || s_empty !== 1'b0) begin
        bad++;
        $display("FAIL fill_%0d: cnt=%0d ae=%b af=%b full=%b empty=%b want cnt=%0d ae=%b af=%b full=%b empty=0",
                 i, s_cnt, s_ae, s_af, s_full, s_empty, i + 1, i + 1 <= AE, i + 1 >= AF, i + 1 == D);
      end
    end
    for (int i = 0; i < D; i++) begin
      total++;
      if (f_dout !== 8'(i)) begin
        bad++;
        $display("FAIL fwft_head_%0d: dout=%h want %h", i, f_dout, 8'(i));
      end
      drive(0, 1, 0, 8'h00);
      total++;
      if (s_dout !== 8'(i) || s_cnt !== CW'(D - 1 - i) || s_empty !== (i == D - 1)) begin
        bad++;
        $display("FAIL drain_%0d: dout=%h cnt=%0d empty=%b want %h %0d %b",
                 i, s_dout, s_cnt, s_empty, 8'(i), D - 1 - i, i == D - 1);
      end
    end
  endtask

  task automatic test_wrap();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) drive(1, 0, 0, 8'($urandom));
      for (int i = 0; i < 10; i++) begin
        drive(0, 1, 0, 8'h00);
        total++;
        if (s_dout !== m_dout) begin
          bad++;
          $display("FAIL wrap_r%0d_%0d: dout=%h want %h", r, i, s_dout, m_dout);
        end
      end
    end
    drive(0, 0, 0, 8'h00);
    total++;
    if (s_cnt !== 0 || s_empty !== 1'b1) begin
      bad++;
      $display("FAIL wrap_end: cnt=%0d empty=%b want 0 1", s_cnt, s_empty);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 8'($urandom));
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 0, 8'($urandom));
      total++;
      if (s_cnt !== 5 || s_dout !== m_dout) begin
        bad++;
        $display("FAIL simul_%0d: cnt=%0d dout=%h want 5 %h", i, s_cnt, s_dout, m_dout);
      end
    end
    while (q.size() < D) drive(1, 0, 0, 8'($urandom));
    drive(1, 1, 0, 8'hEE);
    total++;
    if (s_ovf !== 1'b1 || s_cnt !== 15 || s_dout !== m_dout || s_full !== 1'b0) begin
      bad++;
      $display("FAIL simul_full: ovf=%b cnt=%0d dout=%h full=%b want 1 15 %h 0", s_ovf, s_cnt, s_dout, m_dout, s_full);
    end
    drive(0, 0, 1, 8'h00);
  endtask

  task automatic test_errors();
    while (q.size() < D) drive(1, 0, 0, 8'($urandom));
    drive(1, 0, 0, 8'h77);
    total++;
    if (s_ovf !== 1'b1 || s_cnt !== 16) begin
      bad++;
      $display("FAIL ovf_set: ovf=%b cnt=%0d want 1 16", s_ovf, s_cnt);
    end
    drive(1, 0, 1, 8'h78);
    total++;
    if (s_ovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf_clr_race: ovf=%b want 1", s_ovf);
    end
    while (q.size() > 0) drive(0, 1, 0, 8'h00);
    drive(0, 1, 0, 8'h00);
    total++;
    if (s_ufl !== 1'b1 || s_dout !== m_dout || s_cnt !== 0) begin
      bad++;
      $display("FAIL ufl_set: ufl=%b dout=%h cnt=%0d want 1 %h 0", s_ufl, s_dout, s_cnt, m_dout);
    end
    drive(0, 0, 1, 8'h00);
    total++;
    if (s_ovf !== 1'b0 || s_ufl !== 1'b0 || f_ovf !== 1'b0 || f_ufl !== 1'b0) begin
      bad++;
      $display("FAIL err_clear: ovf=%b ufl=%b fovf=%b fufl=%b want 0 0 0 0", s_ovf, s_ufl, f_ovf, f_ufl);
    end
    drive(0, 0, 0, 8'h00);
  endtask

  task automatic test_fwft();
    drive(1, 0, 0, 8'hA5);
    drive(0, 0, 0, 8'h00);
    total++;
    if (f_dout !== 8'hA5 || f_empty !== 1'b0 || f_cnt !== 1) begin
      bad++;
      $display("FAIL fwft_show: dout=%h empty=%b cnt=%0d want a5 0 1", f_dout, f_empty, f_cnt);
    end
    drive(0, 1, 0, 8'h00);
    total++;
    if (f_empty !== 1'b1 || f_cnt !== 0 || s_dout !== 8'hA5) begin
      bad++;
      $display("FAIL fwft_pop: empty=%b cnt=%0d std_dout=%h want 1 0 a5", f_empty, f_cnt, s_dout);
    end
    drive(0, 0, 0, 8'h00);
  endtask

  task automatic test_random();
    int n;
    for (int i = 0; i < 2000; i++) begin
      drive(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
            1'($urandom_range(0, 99) < 4), 8'($urandom));
      n = q.size();
      total++;
      if (s_cnt !== CW'(n) || s_full !== (n == D) || s_empty !== (n == 0) ||
          s_af !== (n >= AF) || s_ae !== (n <= AE) || s_ovf !== m_ovf || s_ufl !== m_ufl ||
          s_dout !== m_dout || f_cnt !== CW'(n) || f_ovf !== m_ovf || f_ufl !== m_ufl ||
          (n > 0 && f_dout !== q[0])) begin
        bad++;
        $display("FAIL rand_%0d: cnt=%0d full=%b empty=%b af=%b ae=%b ovf=%b ufl=%b dout=%h fdout=%h want cnt=%0d ovf=%b ufl=%b dout=%h head=%h",
                 i, s_cnt, s_full, s_empty, s_af, s_ae, s_ovf, s_ufl, s_dout, f_dout,
                 n, m_ovf, m_ufl, m_dout, (n > 0) ? q[0] : 8'h00);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simultaneous();
    test_errors();
    test_fwft();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
